// File: rtl/tap_pkg.sv
// Shared TAP state codes and helpers for the IEEE 1149.1 state register and the downstream decoder.
package tap_pkg;

  typedef enum logic [3:0] {
    TAP_TLR      = 4'd0,
    TAP_RTI      = 4'd1,
    TAP_SEL_DR   = 4'd2,
    TAP_SEL_IR   = 4'd3,
    TAP_CAP_DR   = 4'd4,
    TAP_SH_DR    = 4'd5,
    TAP_EX1_DR   = 4'd6,
    TAP_PAUSE_DR = 4'd7,
    TAP_EX2_DR   = 4'd8,
    TAP_UP_DR    = 4'd9,
    TAP_CAP_IR   = 4'd10,
    TAP_SH_IR    = 4'd11,
    TAP_EX1_IR   = 4'd12,
    TAP_PAUSE_IR = 4'd13,
    TAP_EX2_IR   = 4'd14,
    TAP_UP_IR    = 4'd15
  } tap_state_t;

  // Select-DR plus the whole DR column, Capture-DR through Update-DR.
  function automatic logic is_dr_path(input tap_state_t state);
    logic result;
    case (state)
      TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR,
      TAP_PAUSE_DR, TAP_EX2_DR, TAP_UP_DR: result = 1'b1;
      default:                             result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/tap_next_state.sv
// Combinational TAP transition graph: next state from current state and TMS.
module tap_next_state
  import tap_pkg::*;
(
  input  tap_state_t code,
  input  logic       tms,
  output tap_state_t next_code
);

  // Transition table; each arm is the TMS=1 / TMS=0 successor.
  always_comb begin
    next_code = TAP_TLR;
    case (code)
      TAP_TLR:      next_code = tms ? TAP_TLR      : TAP_RTI;
      TAP_RTI:      next_code = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_SEL_DR:   next_code = tms ? TAP_SEL_IR   : TAP_CAP_DR;
      TAP_SEL_IR:   next_code = tms ? TAP_TLR      : TAP_CAP_IR;
      TAP_CAP_DR:   next_code = tms ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_SH_DR:    next_code = tms ? TAP_EX1_DR   : TAP_SH_DR;
      TAP_EX1_DR:   next_code = tms ? TAP_UP_DR    : TAP_PAUSE_DR;
      TAP_PAUSE_DR: next_code = tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
      TAP_EX2_DR:   next_code = tms ? TAP_UP_DR    : TAP_SH_DR;
      TAP_UP_DR:    next_code = tms ? TAP_SEL_DR   : TAP_RTI;
      TAP_CAP_IR:   next_code = tms ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_SH_IR:    next_code = tms ? TAP_EX1_IR   : TAP_SH_IR;
      TAP_EX1_IR:   next_code = tms ? TAP_UP_IR    : TAP_PAUSE_IR;
      TAP_PAUSE_IR: next_code = tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
      TAP_EX2_IR:   next_code = tms ? TAP_UP_IR    : TAP_SH_IR;
      TAP_UP_IR:    next_code = tms ? TAP_SEL_DR   : TAP_RTI;
      default:      next_code = TAP_TLR;
    endcase
  end

endmodule

// File: rtl/tap_state_fsm.sv
// TAP controller state register with state-change strobe and DR-path flag.
// Optional Run-Test/Idle cycle counter enabled by defining TAP_RTI_CNT_EN.
module tap_state_fsm
  import tap_pkg::*;
#(
  parameter int RTI_CNT_W = 16
) (
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output logic [3:0] code,
  output logic       state_chg,
  output logic       dr_path
`ifdef TAP_RTI_CNT_EN
  ,
  output logic [RTI_CNT_W-1:0] rti_cnt
`endif
);

  if (RTI_CNT_W < 1 || RTI_CNT_W > 32) begin : g_bad_width
    $error("tap_state_fsm: RTI_CNT_W must be in 1..32");
  end

  tap_state_t code_r;
  tap_state_t next_code_s;
  logic       state_chg_r;
  logic       dr_path_r;
  logic       state_chg_s;
  logic       dr_path_s;

  tap_next_state u_next_state (
    .code      (code_r),
    .tms       (tms),
    .next_code (next_code_s)
  );

  // Strobe and DR flag are derived from the next state so they register alongside CODE.
  always_comb begin
    state_chg_s = (next_code_s != code_r);
    dr_path_s   = is_dr_path(next_code_s);
  end

  // State, strobe and DR-path registers; reset wins over TMS.
  always_ff @(posedge tck) begin
    if (!trst_n) begin
      code_r      <= TAP_TLR;
      state_chg_r <= 1'b0;
      dr_path_r   <= 1'b0;
    end else begin
      code_r      <= next_code_s;
      state_chg_r <= state_chg_s;
      dr_path_r   <= dr_path_s;
    end
  end

  assign code      = code_r;
  assign state_chg = state_chg_r;
  assign dr_path   = dr_path_r;

`ifdef TAP_RTI_CNT_EN
  logic [RTI_CNT_W-1:0] rti_cnt_r;
  logic [RTI_CNT_W-1:0] rti_cnt_s;

  // Counts consecutive edges landing in RTI, holding at all-ones.
  always_comb begin
    rti_cnt_s = {RTI_CNT_W{1'b0}};
    if (next_code_s == TAP_RTI) begin
      if (code_r != TAP_RTI) begin
        rti_cnt_s = RTI_CNT_W'(1);
      end else if (rti_cnt_r != {RTI_CNT_W{1'b1}}) begin
        rti_cnt_s = rti_cnt_r + RTI_CNT_W'(1);
      end else begin
        rti_cnt_s = rti_cnt_r;
      end
    end else begin
      rti_cnt_s = {RTI_CNT_W{1'b0}};
    end
  end

  // Counter register.
  always_ff @(posedge tck) begin
    if (!trst_n) begin
      rti_cnt_r <= {RTI_CNT_W{1'b0}};
    end else begin
      rti_cnt_r <= rti_cnt_s;
    end
  end

  assign rti_cnt = rti_cnt_r;
`endif

endmodule

// File: tb/tb_tap_state_fsm.sv
// Directed testbench for tap_state_fsm; counter checks run when TAP_RTI_CNT_EN is defined.
module tb_tap_state_fsm;

  logic       tck;
  logic       trst_n;
  logic       tms;
  logic [3:0] code;
  logic       state_chg;
  logic       dr_path;
`ifdef TAP_RTI_CNT_EN
  logic [1:0] rti_cnt;
`endif

  int errors;
  int checks;

  tap_state_fsm #(.RTI_CNT_W(2)) dut (
    .tck       (tck),
    .trst_n    (trst_n),
    .tms       (tms),
    .code      (code),
    .state_chg (state_chg),
    .dr_path   (dr_path)
`ifdef TAP_RTI_CNT_EN
    ,
    .rti_cnt   (rti_cnt)
`endif
  );

  initial tck = 1'b0;
  always #5 tck = ~tck;

  // Drive TMS, take one rising edge, then settle before sampling.
  task automatic tick(input logic t);
    tms = t;
    @(posedge tck);
    #1;
  endtask

  task automatic do_reset();
    trst_n = 1'b0;
    tick(1'b0);
    trst_n = 1'b1;
  endtask

  task automatic test_reset();
    trst_n = 1'b0;
    tick(1'b0);
    tick(1'b0);
    checks++; if (code !== 4'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", code); end
    checks++; if (state_chg !== 1'b0) begin errors++; $display("FAIL reset_chg got=%b exp=0", state_chg); end
    checks++; if (dr_path !== 1'b0) begin errors++; $display("FAIL reset_dr got=%b exp=0", dr_path); end
`ifdef TAP_RTI_CNT_EN
    checks++; if (rti_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", rti_cnt); end
`endif
    trst_n = 1'b1;
  endtask

  task automatic test_dr_scan();
    logic       tv [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] ec [8] = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd5, 4'd6, 4'd9, 4'd1};
    logic       eg [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       ed [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      tick(tv[i]);
      checks++; if (code !== ec[i]) begin errors++; $display("FAIL dr_code[%0d] got=%0d exp=%0d", i, code, ec[i]); end
      checks++; if (state_chg !== eg[i]) begin errors++; $display("FAIL dr_chg[%0d] got=%b exp=%b", i, state_chg, eg[i]); end
      checks++; if (dr_path !== ed[i]) begin errors++; $display("FAIL dr_path[%0d] got=%b exp=%b", i, dr_path, ed[i]); end
    end
  endtask

  task automatic test_ir_scan();
    logic       tv [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] ec [10] = '{4'd2, 4'd3, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd11, 4'd12, 4'd15};
    logic       ed [10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset();
    tick(1'b0);
    checks++; if (code !== 4'd1) begin errors++; $display("FAIL ir_start got=%0d exp=1", code); end
    for (int i = 0; i < 10; i++) begin
      tick(tv[i]);
      checks++; if (code !== ec[i]) begin errors++; $display("FAIL ir_code[%0d] got=%0d exp=%0d", i, code, ec[i]); end
      checks++; if (dr_path !== ed[i]) begin errors++; $display("FAIL ir_path[%0d] got=%b exp=%b", i, dr_path, ed[i]); end
      checks++; if (state_chg !== 1'b1) begin errors++; $display("FAIL ir_chg[%0d] got=%b exp=1", i, state_chg); end
    end
  endtask

  task automatic test_five_ones();
    // TMS path from TLR to each state, applied MSB first over plen bits.
    int         plen [16] = '{0, 1, 2, 3, 3, 4, 4, 5, 6, 5, 4, 5, 5, 6, 7, 6};
    logic [6:0] pbit [16] = '{7'b0000000, 7'b0000000, 7'b0000001, 7'b0000011,
                              7'b0000010, 7'b0000100, 7'b0000101, 7'b0001010,
                              7'b0010101, 7'b0001011, 7'b0000110, 7'b0001100,
                              7'b0001101, 7'b0011010, 7'b0110101, 7'b0011011};
    for (int s = 0; s < 16; s++) begin
      do_reset();
      for (int b = plen[s] - 1; b >= 0; b--) tick(pbit[s][b]);
      checks++; if (code !== 4'(s)) begin errors++; $display("FAIL reach[%0d] got=%0d exp=%0d", s, code, s); end
      for (int k = 0; k < 5; k++) tick(1'b1);
      checks++; if (code !== 4'd0) begin errors++; $display("FAIL five_ones[%0d] got=%0d exp=0", s, code); end
    end
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b0);
    checks++; if (code !== 4'd5) begin errors++; $display("FAIL mid_pre got=%0d exp=5", code); end
    trst_n = 1'b0;
    tick(1'b1);
    checks++; if (code !== 4'd0) begin errors++; $display("FAIL mid_code got=%0d exp=0", code); end
    checks++; if (state_chg !== 1'b0) begin errors++; $display("FAIL mid_chg got=%b exp=0", state_chg); end
    checks++; if (dr_path !== 1'b0) begin errors++; $display("FAIL mid_dr got=%b exp=0", dr_path); end
    trst_n = 1'b1;
    tick(1'b0);
    checks++; if (code !== 4'd1) begin errors++; $display("FAIL mid_exit got=%0d exp=1", code); end
    checks++; if (state_chg !== 1'b1) begin errors++; $display("FAIL mid_exit_chg got=%b exp=1", state_chg); end
    do_reset();
    tick(1'b1);
    checks++; if (code !== 4'd0) begin errors++; $display("FAIL tlr_hold got=%0d exp=0", code); end
    checks++; if (state_chg !== 1'b0) begin errors++; $display("FAIL tlr_hold_chg got=%b exp=0", state_chg); end
  endtask

`ifdef TAP_RTI_CNT_EN
  task automatic test_rti_cnt();
    logic [1:0] ev [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b0);
      checks++; if (rti_cnt !== ev[i]) begin errors++; $display("FAIL rti_cnt[%0d] got=%0d exp=%0d", i, rti_cnt, ev[i]); end
    end
    tick(1'b1);
    checks++; if (code !== 4'd2) begin errors++; $display("FAIL rti_exit_code got=%0d exp=2", code); end
    checks++; if (rti_cnt !== 2'd0) begin errors++; $display("FAIL rti_exit_cnt got=%0d exp=0", rti_cnt); end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    trst_n = 1'b0;
    tms    = 1'b0;
    test_reset();
    test_dr_scan();
    test_ir_scan();
    test_five_ones();
    test_reset_mid_scan();
`ifdef TAP_RTI_CNT_EN
    test_rti_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
